// File: rtl/k580vt57_pkg.sv
// Shared types for the K580VT57 DMA controller: FSM encoding, transfer types, mode bits.
package k580vt57_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_S1,
        ST_S2,
        ST_S3
    } state_t;

    localparam logic [1:0] XFER_VERIFY = 2'b00;
    localparam logic [1:0] XFER_WRITE  = 2'b01;
    localparam logic [1:0] XFER_READ   = 2'b10;

    localparam int MODE_ROT      = 4;
    localparam int MODE_EXTW     = 5;
    localparam int MODE_TCSTOP   = 6;
    localparam int MODE_AUTOLOAD = 7;

    // Count register view: type in the top two bits, 14-bit count below.
    typedef struct packed {
        logic [1:0]  xtype;
        logic [13:0] count;
    } cnt_t;

endpackage

// File: rtl/k580vt57_arb.sv
// Purpose: 4-way DMA request arbiter, fixed (ch0 first) or rotating from last served.
// Latency: grant is combinational; the last-served pointer updates on upd.
// Backpressure: none; the caller decides when a grant is taken.
module k580vt57_arb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       rotate,
    input  logic       upd,
    input  logic [1:0] upd_ch,
    output logic       gnt_vld,
    output logic [1:0] gnt_ch
);

    logic [1:0] last_q;
    logic [1:0] last_eff;
    logic [1:0] base;
    logic [1:0] idx;

    // The channel finishing this cycle already counts as last served for re-arbitration.
    assign last_eff = upd ? upd_ch : last_q;
    assign base     = rotate ? last_eff + 2'd1 : 2'd0;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = 2'd0;
        idx     = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = base + 2'(i);
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_ch  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q <= 2'd3;
        end else if (upd) begin
            last_q <= upd_ch;
        end
    end

endmodule

// File: rtl/k580vt57.sv
// Purpose: K580VT57 / i8257 four-channel DMA controller with CPU register port.
// Latency: IDLE->WAIT->S1->S2->S3 per transfer, one step per ce; S3 bursts straight to S1.
// Backpressure: waits in WAIT until hlda; hlda low at S3 ends the burst.
module k580vt57
    import k580vt57_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [3:0]  iaddr,
    input  logic [7:0]  idata,
    output logic [7:0]  odata,
    input  logic        iwe_n,
    input  logic        ird_n,
    input  logic [3:0]  drq,
    output logic [3:0]  dack,
    output logic        hrq,
    input  logic        hlda,
    output logic [15:0] oaddr,
    output logic        memr_n,
    output logic        memw_n,
    output logic        ior_n,
    output logic        iow_n,
    output logic        tc
);

    state_t      state_q, state_d;
    logic [15:0] addr_q [4];
    logic [15:0] cnt_q  [4];
    logic [7:0]  mode_q;
    logic [3:0]  tc_flag_q;
    logic        bptr_q;
    logic [1:0]  ch_q, ch_d;
    logic        hrq_q, hrq_d;
    logic        iwe_n_q, ird_n_q;

    logic        we_evt, rd_evt;
    logic [1:0]  wr_ch;
    logic [3:0]  wr_sel;
    cnt_t        cur_cnt;
    logic        tc_now, active, in_s2, s3_step, update;
    logic [3:0]  req;
    logic        gnt_vld;
    logic [1:0]  gnt_ch;
    logic [15:0] rd_word;
    logic        ext_write_unused;

    assign we_evt  = iwe_n & ~iwe_n_q;
    assign rd_evt  = ird_n & ~ird_n_q;
    assign wr_ch   = iaddr[2:1];
    assign wr_sel  = (4'b0001 << wr_ch) | ((mode_q[MODE_AUTOLOAD] && wr_ch == 2'd2) ? 4'b1000 : 4'b0000);
    assign cur_cnt = cnt_q[ch_q];
    assign tc_now  = (cur_cnt.count == 14'd0);
    assign active  = (state_q == ST_S1) || (state_q == ST_S2) || (state_q == ST_S3);
    assign in_s2   = (state_q == ST_S2);
    assign s3_step = ce && (state_q == ST_S3);
    assign update  = (state_q == ST_S3) && (ch_q == 2'd2) && mode_q[MODE_AUTOLOAD] && tc_now;
    assign ext_write_unused = mode_q[MODE_EXTW];

    // A channel stopped by its own terminal count must not win the burst re-arbitration.
    always_comb begin
        req = drq & mode_q[3:0];
        if (state_q == ST_S3 && tc_now && mode_q[MODE_TCSTOP]) begin
            req[ch_q] = 1'b0;
        end
    end

    k580vt57_arb u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .rotate  (mode_q[MODE_ROT]),
        .upd     (s3_step),
        .upd_ch  (ch_q),
        .gnt_vld (gnt_vld),
        .gnt_ch  (gnt_ch)
    );

    always_comb begin
        state_d = state_q;
        hrq_d   = hrq_q;
        ch_d    = ch_q;
        if (ce) begin
            case (state_q)
                ST_IDLE: if (|req) begin
                    hrq_d   = 1'b1;
                    state_d = ST_WAIT;
                end
                ST_WAIT: if (!(|req)) begin
                    hrq_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (hlda) begin
                    ch_d    = gnt_ch;
                    state_d = ST_S1;
                end
                ST_S1: state_d = ST_S2;
                ST_S2: state_d = ST_S3;
                ST_S3: if (hlda && gnt_vld) begin
                    ch_d    = gnt_ch;
                    state_d = ST_S1;
                end else begin
                    hrq_d   = 1'b0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            hrq_q     <= 1'b0;
            ch_q      <= 2'd0;
            mode_q    <= 8'h00;
            tc_flag_q <= 4'h0;
            bptr_q    <= 1'b0;
            iwe_n_q   <= 1'b1;
            ird_n_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            hrq_q   <= hrq_d;
            ch_q    <= ch_d;
            iwe_n_q <= iwe_n;
            ird_n_q <= ird_n;
            if (we_evt) begin
                if (!iaddr[3]) begin
                    bptr_q <= ~bptr_q;
                end else if (iaddr == 4'd8) begin
                    mode_q <= idata;
                    bptr_q <= 1'b0;
                end
            end
            if (rd_evt) begin
                if (!iaddr[3]) begin
                    bptr_q <= ~bptr_q;
                end else if (iaddr == 4'd8) begin
                    tc_flag_q <= 4'h0;
                end
            end
            if (s3_step && tc_now) begin
                tc_flag_q[ch_q] <= 1'b1;
                if (mode_q[MODE_TCSTOP]) begin
                    mode_q[{1'b0, ch_q}] <= 1'b0;
                end
            end
        end
    end

    // Address/count survive reset; the S3 update is written last so it wins over a CPU write.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int n = 0; n < 4; n++) begin
                if (we_evt && !iaddr[3] && wr_sel[n]) begin
                    if (iaddr[0]) begin
                        if (bptr_q) cnt_q[n][15:8] <= idata;
                        else        cnt_q[n][7:0]  <= idata;
                    end else begin
                        if (bptr_q) addr_q[n][15:8] <= idata;
                        else        addr_q[n][7:0]  <= idata;
                    end
                end
            end
            if (s3_step) begin
                addr_q[ch_q] <= addr_q[ch_q] + 16'd1;
                cnt_q[ch_q]  <= {cur_cnt.xtype, cur_cnt.count - 14'd1};
                if (update) begin
                    addr_q[2] <= addr_q[3];
                    cnt_q[2]  <= cnt_q[3];
                end
            end
        end
    end

    assign hrq    = hrq_q;
    assign dack   = active ? (4'b0001 << ch_q) : 4'b0000;
    assign oaddr  = active ? addr_q[ch_q] : 16'h0000;
    assign memr_n = !(in_s2 && cur_cnt.xtype == XFER_READ);
    assign iow_n  = !(in_s2 && cur_cnt.xtype == XFER_READ);
    assign memw_n = !(in_s2 && cur_cnt.xtype == XFER_WRITE);
    assign ior_n  = !(in_s2 && cur_cnt.xtype == XFER_WRITE);
    assign tc     = (in_s2 || state_q == ST_S3) && tc_now;

    always_comb begin
        rd_word = iaddr[0] ? cnt_q[iaddr[2:1]] : addr_q[iaddr[2:1]];
        odata   = 8'h00;
        if (!iaddr[3]) begin
            odata = bptr_q ? rd_word[15:8] : rd_word[7:0];
        end else if (iaddr == 4'd8) begin
            odata = {3'b000, update, tc_flag_q};
        end
    end

endmodule

// File: tb/tb_k580vt57.sv
// Directed bench for the K580VT57 DMA controller with immediate-assertion checks.
module tb_k580vt57;
    import k580vt57_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, ce;
    logic [3:0]  iaddr;
    logic [7:0]  idata, odata;
    logic        iwe_n, ird_n;
    logic [3:0]  drq, dack;
    logic        hrq, hlda, hlda_echo, hlda_man;
    logic [15:0] oaddr;
    logic        memr_n, memw_n, ior_n, iow_n, tc;
    int          checks = 0;
    int          errors = 0;

    assign hlda = hlda_echo ? hrq : hlda_man;

    always #5 clk = ~clk;

    k580vt57 dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .iaddr(iaddr), .idata(idata), .odata(odata),
        .iwe_n(iwe_n), .ird_n(ird_n), .drq(drq), .dack(dack), .hrq(hrq), .hlda(hlda),
        .oaddr(oaddr), .memr_n(memr_n), .memw_n(memw_n), .ior_n(ior_n), .iow_n(iow_n), .tc(tc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
        iaddr = a; idata = d; iwe_n = 1'b0;
        step();
        iwe_n = 1'b1;
        step();
    endtask

    task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
        iaddr = a; ird_n = 1'b0;
        step();
        d = odata;
        ird_n = 1'b1;
        step();
    endtask

    task automatic prog_ch(input logic [1:0] ch, input logic [15:0] a, input logic [15:0] c);
        cpu_wr({1'b0, ch, 1'b0}, a[7:0]);
        cpu_wr({1'b0, ch, 1'b0}, a[15:8]);
        cpu_wr({1'b0, ch, 1'b1}, c[7:0]);
        cpu_wr({1'b0, ch, 1'b1}, c[15:8]);
    endtask

    task automatic wait_s2(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!memr_n || !memw_n) begin
                seen = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Leaves the bench inside S2 of a read transfer; the caller steps on.
    task automatic xfer(input string tag, input logic [3:0] exp_dack, input logic [15:0] exp_addr,
                        input logic exp_tc);
        bit seen;
        wait_s2(seen);
        chk({tag, "_seen"}, 16'(seen), 16'd1);
        chk({tag, "_oaddr"}, oaddr, exp_addr);
        chk({tag, "_dack"}, 16'(dack), 16'(exp_dack));
        chk({tag, "_strobes"}, 16'({memr_n, iow_n, memw_n, ior_n}), 16'b0011);
        chk({tag, "_tc"}, 16'(tc), 16'(exp_tc));
    endtask

    initial begin
        logic [7:0] rd;
        bit         seen;
        reset_n = 1'b0; ce = 1'b1; iaddr = 4'd0; idata = 8'd0; iwe_n = 1'b1; ird_n = 1'b1;
        drq = 4'd0; hlda_echo = 1'b0; hlda_man = 1'b0;
        step(); step(); step();
        chk("rst_hrq", 16'(hrq), 16'd0);
        chk("rst_dack", 16'(dack), 16'd0);
        chk("rst_strobes", 16'({memr_n, iow_n, memw_n, ior_n}), 16'b1111);
        chk("rst_tc", 16'(tc), 16'd0);
        reset_n = 1'b1;
        step();
        cpu_rd(4'd8, rd);
        chk("rst_status", 16'(rd), 16'h00);
        drq = 4'hF;
        step(); step(); step(); step();
        chk("rst_mode0_hrq", 16'(hrq), 16'd0);
        drq = 4'h0;

        // Plain read transfers on channel 2.
        cpu_wr(4'd8, 8'h00);
        prog_ch(2'd2, 16'h1000, 16'h8003);
        cpu_rd(4'd4, rd); chk("rb_addr_lo", 16'(rd), 16'h00);
        cpu_rd(4'd4, rd); chk("rb_addr_hi", 16'(rd), 16'h10);
        cpu_rd(4'd5, rd); chk("rb_cnt_lo", 16'(rd), 16'h03);
        cpu_rd(4'd5, rd); chk("rb_cnt_hi", 16'(rd), 16'h80);
        cpu_wr(4'd8, 8'h04);
        hlda_echo = 1'b1;
        drq = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            xfer("rd", 4'b0100, 16'h1000 + 16'(i), (i == 3));
            if (i == 3) drq = 4'b0000;
            step();
        end
        chk("rd_s3_tc", 16'(tc), 16'd1);
        chk("rd_s3_strobes", 16'({memr_n, iow_n, memw_n, ior_n}), 16'b1111);
        step();
        chk("rd_end_hrq", 16'(hrq), 16'd0);
        chk("rd_end_dack", 16'(dack), 16'd0);
        cpu_rd(4'd8, rd); chk("rd_status_tc", 16'(rd), 16'h04);
        cpu_rd(4'd8, rd); chk("rd_status_clr", 16'(rd), 16'h00);

        // TC stop disables the channel after its last transfer.
        cpu_wr(4'd8, 8'h44);
        prog_ch(2'd2, 16'h1000, 16'h8003);
        drq = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            xfer("tcs", 4'b0100, 16'h1000 + 16'(i), (i == 3));
            step();
        end
        wait_s2(seen);
        chk("tcs_no_more", 16'(seen), 16'd0);
        chk("tcs_hrq", 16'(hrq), 16'd0);
        chk("tcs_dack", 16'(dack), 16'd0);
        drq = 4'b0000;
        cpu_rd(4'd8, rd); chk("tcs_status", 16'(rd), 16'h04);

        // Autoload reloads channel 2 from channel 3 and keeps going.
        cpu_wr(4'd8, 8'h84);
        prog_ch(2'd2, 16'h2000, 16'h8001);
        drq = 4'b0100;
        xfer("al0", 4'b0100, 16'h2000, 1'b0);
        step();
        xfer("al1", 4'b0100, 16'h2001, 1'b1);
        iaddr = 4'd8;
        step();
        chk("al_update", 16'(odata), 16'h10);
        step();
        chk("al_after", 16'(odata), 16'h04);
        chk("al_reload_addr", oaddr, 16'h2000);
        xfer("al2", 4'b0100, 16'h2000, 1'b0);
        step();
        xfer("al3", 4'b0100, 16'h2001, 1'b1);
        drq = 4'b0000;
        step(); step(); step();
        chk("al_end_hrq", 16'(hrq), 16'd0);
        cpu_rd(4'd8, rd); chk("al_status", 16'(rd), 16'h04);

        // Fixed priority, then reset in the middle of S2.
        cpu_wr(4'd8, 8'h0F);
        prog_ch(2'd0, 16'h3000, 16'h80FF);
        prog_ch(2'd1, 16'h4000, 16'h80FF);
        prog_ch(2'd2, 16'h6000, 16'h80FF);
        prog_ch(2'd3, 16'h5000, 16'h80FF);
        drq = 4'hF;
        for (int i = 0; i < 3; i++) begin
            xfer("fix", 4'b0001, 16'h3000 + 16'(i), 1'b0);
            step();
        end
        wait_s2(seen);
        chk("mid_seen", 16'(seen), 16'd1);
        chk("mid_dack", 16'(dack), 16'b0001);
        reset_n = 1'b0;
        step();
        chk("mid_rst_strobes", 16'({memr_n, iow_n, memw_n, ior_n}), 16'b1111);
        chk("mid_rst_dack", 16'(dack), 16'd0);
        chk("mid_rst_hrq", 16'(hrq), 16'd0);
        reset_n = 1'b1;
        cpu_rd(4'd8, rd); chk("mid_rst_status", 16'(rd), 16'h00);
        step(); step();
        chk("mid_rst_mode0", 16'(hrq), 16'd0);

        // Rotating priority: 0,1,2,3,0.
        cpu_wr(4'd8, 8'h1F);
        xfer("rot0", 4'b0001, 16'h3003, 1'b0); step();
        xfer("rot1", 4'b0010, 16'h4000, 1'b0); step();
        xfer("rot2", 4'b0100, 16'h6000, 1'b0); step();
        xfer("rot3", 4'b1000, 16'h5000, 1'b0); step();
        xfer("rot4", 4'b0001, 16'h3004, 1'b0);
        drq = 4'h0;
        step(); step(); step();
        chk("rot_end_hrq", 16'(hrq), 16'd0);

        // Grant withheld: parks in WAIT, then drops the request.
        cpu_wr(4'd8, 8'h04);
        hlda_echo = 1'b0;
        hlda_man  = 1'b0;
        ce  = 1'b0;
        drq = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            ce = 1'b1; step();
            ce = 1'b0; step();
        end
        chk("wait_hrq", 16'(hrq), 16'd1);
        chk("wait_dack", 16'(dack), 16'd0);
        chk("wait_state", 16'(dut.state_q), 16'(ST_WAIT));
        drq = 4'b0000;
        ce  = 1'b1;
        step();
        chk("wait_drop_hrq", 16'(hrq), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
